// File: rtl/touch_scan_ctrl.sv
// Touch-panel scan controller: an autonomous Avalon-MM master that drives an
// SPI master core to read X and Y from an ADS7843-style ADC once per scan
// period while the pen is down, then publishes both with a one-cycle strobe.
module touch_scan_ctrl #(
  parameter int unsigned SCAN_PERIOD = 500000,
  parameter int unsigned DEBOUNCE    = 50000,
  parameter int unsigned TIMEOUT     = 32768,
  parameter logic [7:0]  CMD_X       = 8'hD0,
  parameter logic [7:0]  CMD_Y       = 8'h90
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pen_irq_n,
  output logic        spi_select,
  output logic [2:0]  spi_mem_addr,
  output logic        spi_write_n,
  output logic        spi_read_n,
  output logic [15:0] spi_wdata,
  input  logic [15:0] spi_rdata,
  input  logic        spi_readyfordata,
  input  logic        spi_dataavailable,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        sample_valid,
  output logic        pen_down,
  output logic        busy,
  output logic        timeout_err
);

  localparam int PERIOD_W = $clog2(SCAN_PERIOD) + 1;
  localparam int DEB_W    = $clog2(DEBOUNCE + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);

  localparam logic [PERIOD_W-1:0] PERIOD_RELOAD = PERIOD_W'(SCAN_PERIOD - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_ONE    = PERIOD_W'(1);
  localparam logic [DEB_W-1:0]    DEB_LAST      = DEB_W'(DEBOUNCE - 1);
  localparam logic [DEB_W-1:0]    DEB_ONE       = DEB_W'(1);
  localparam logic [TMO_W-1:0]    TMO_LAST      = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]    TMO_ONE       = TMO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SSO_ON,
    S_WAIT_TRDY,
    S_WR_TX,
    S_WAIT_RRDY,
    S_RD_RX,
    S_SSO_OFF,
    S_PUBLISH
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [1:0]          phase;
  logic [1:0]          byte_idx;
  logic                coord_y;
  logic [6:0]          rx1;
  logic [11:0]         x_shadow;
  logic [11:0]         y_shadow;
  logic                abort_frame;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [PERIOD_W-1:0] period_cnt;
  logic [DEB_W-1:0]    deb_cnt;
  logic                pen_meta;
  logic                pen_sync;
  logic                is_access;
  logic                access_end;
  logic                frame_start;
  logic                tmo_hit;
  logic                publish_ok;
  logic                unused_rdata;

  // Only bits [7:3] of byte 2 and [6:0] of byte 1 carry conversion data.
  assign unused_rdata = ^{spi_rdata[15:8], spi_rdata[2:0]};

  assign is_access  = (state == S_SSO_ON) || (state == S_WR_TX) ||
                      (state == S_RD_RX)  || (state == S_SSO_OFF);
  assign access_end = (phase == 2'd2);
  assign busy       = (state != S_IDLE);
  assign publish_ok = (state == S_PUBLISH) && !pen_sync && !abort_frame && enable;

  // Two-flop synchroniser for the asynchronous pen interrupt (idle = pen up).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pen_meta <= 1'b1;
      pen_sync <= 1'b1;
    end else begin
      pen_meta <= pen_irq_n;
      pen_sync <= pen_meta;
    end
  end

  // Debounce runs only in IDLE because the ADC disturbs PENIRQ while converting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt  <= '0;
      pen_down <= 1'b0;
    end else if (state == S_IDLE) begin
      if (pen_sync != pen_down) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt  <= '0;
        pen_down <= ~pen_down;
      end else begin
        deb_cnt <= deb_cnt + DEB_ONE;
      end
    end
  end

  // Frame pacing: reload at frame start, count down to zero and hold there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
    end else if (frame_start) begin
      period_cnt <= PERIOD_RELOAD;
    end else if (period_cnt != '0) begin
      period_cnt <= period_cnt - PERIOD_ONE;
    end
  end

  // State register plus the phase counter that times each 2-cycle bus access and its idle gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      phase <= 2'd0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        phase <= 2'd0;
      end else if (is_access && !access_end) begin
        phase <= phase + 2'd1;
      end
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && pen_down && (period_cnt == '0)) begin
          state_next  = S_SSO_ON;
          frame_start = 1'b1;
        end
      end
      S_SSO_ON: begin
        if (access_end) state_next = S_WAIT_TRDY;
      end
      S_WAIT_TRDY: begin
        if (!enable) state_next = S_SSO_OFF;
        else if (spi_readyfordata) state_next = S_WR_TX;
      end
      S_WR_TX: begin
        if (access_end) state_next = S_WAIT_RRDY;
      end
      S_WAIT_RRDY: begin
        if (spi_dataavailable) begin
          state_next = S_RD_RX;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          state_next = S_SSO_OFF;
        end
      end
      S_RD_RX: begin
        if (access_end) begin
          if (!enable || ((byte_idx == 2'd2) && coord_y)) state_next = S_SSO_OFF;
          else state_next = S_WAIT_TRDY;
        end
      end
      S_SSO_OFF: begin
        if (access_end) state_next = abort_frame ? S_IDLE : S_PUBLISH;
      end
      S_PUBLISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Bus drive: address, select, data and strobe held for phases 0 and 1, idle in phase 2.
  always_comb begin
    spi_select   = 1'b0;
    spi_mem_addr = 3'd0;
    spi_write_n  = 1'b1;
    spi_read_n   = 1'b1;
    spi_wdata    = 16'h0000;
    if (is_access && !access_end) begin
      spi_select = 1'b1;
      case (state)
        S_SSO_ON: begin
          spi_mem_addr = 3'd3;
          spi_write_n  = 1'b0;
          spi_wdata    = 16'h0400;
        end
        S_WR_TX: begin
          spi_mem_addr = 3'd1;
          spi_write_n  = 1'b0;
          if (byte_idx == 2'd0) spi_wdata = {8'h00, coord_y ? CMD_Y : CMD_X};
        end
        S_RD_RX: begin
          spi_mem_addr = 3'd0;
          spi_read_n   = 1'b0;
        end
        default: begin
          spi_mem_addr = 3'd3;
          spi_write_n  = 1'b0;
        end
      endcase
    end
  end

  // Byte/coordinate bookkeeping, read-data capture and abort tracking for the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx    <= 2'd0;
      coord_y     <= 1'b0;
      rx1         <= 7'd0;
      x_shadow    <= 12'd0;
      y_shadow    <= 12'd0;
      abort_frame <= 1'b0;
    end else begin
      if (frame_start) begin
        byte_idx    <= 2'd0;
        coord_y     <= 1'b0;
        abort_frame <= 1'b0;
      end else if (tmo_hit || ((state != S_IDLE) && !enable)) begin
        abort_frame <= 1'b1;
      end
      if ((state == S_RD_RX) && (phase == 2'd1)) begin
        if (byte_idx == 2'd1) rx1 <= spi_rdata[6:0];
        if (byte_idx == 2'd2) begin
          if (coord_y) y_shadow <= {rx1, spi_rdata[7:3]};
          else x_shadow <= {rx1, spi_rdata[7:3]};
        end
      end
      if ((state == S_RD_RX) && access_end) begin
        if (byte_idx == 2'd2) begin
          byte_idx <= 2'd0;
          coord_y  <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

  // Per-byte watchdog: restarts whenever the FSM is outside WAIT_RRDY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT_RRDY) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

  // Sticky timeout flag, held clear while scanning is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err <= 1'b0;
    end else if (!enable) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end
  end

  // Publish coordinates and the strobe together so they appear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_pos        <= 12'd0;
      y_pos        <= 12'd0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= publish_ok;
      if (publish_ok) begin
        x_pos <= x_shadow;
        y_pos <= y_shadow;
      end
    end
  end

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Testbench for touch_scan_ctrl: SPI-core register model with an ADS7843-style
// response generator, scaled-down timing parameters, and directed scenarios.
module tb_touch_scan_ctrl;

  localparam int SP        = 2000;
  localparam int DEB       = 50;
  localparam int TMO       = 200;
  localparam int BYTE_TIME = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        pen_irq_n;
  logic        spi_select;
  logic [2:0]  spi_mem_addr;
  logic        spi_write_n;
  logic        spi_read_n;
  logic [15:0] spi_wdata;
  logic [15:0] spi_rdata;
  logic        spi_readyfordata;
  logic        spi_dataavailable;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        sample_valid;
  logic        pen_down;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  // SPI core / ADC model state
  logic [7:0]  rx_reg = 8'h00;
  logic        sso = 1'b0;
  int          busy_cnt = 0;
  int          adc_phase = 0;
  logic [11:0] adc_val = 12'h000;
  logic [11:0] x_val = 12'hA5C;
  logic [11:0] y_val = 12'h3F1;
  logic        mute_rrdy = 1'b0;
  logic [7:0]  cur_tx = 8'h00;
  logic        prev_wr_n = 1'b1;
  logic        prev_rd_n = 1'b1;
  logic [7:0]  mosi_q[$];
  int          cycle = 0;
  int          last_tx_cycle = 0;

  // Monitors
  int          sv_count = 0;
  int          sv_time[$];
  int          sel_cycles = 0;
  logic        pd_seen = 1'b0;
  int          strobe_run = 0;
  int          proto_err = 0;

  logic [7:0]  exp_mosi [6] = '{8'hD0, 8'h00, 8'h00, 8'h90, 8'h00, 8'h00};

  assign spi_rdata = {8'h00, rx_reg};

  touch_scan_ctrl #(
    .SCAN_PERIOD(SP), .DEBOUNCE(DEB), .TIMEOUT(TMO), .CMD_X(8'hD0), .CMD_Y(8'h90)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pen_irq_n(pen_irq_n),
    .spi_select(spi_select), .spi_mem_addr(spi_mem_addr), .spi_write_n(spi_write_n),
    .spi_read_n(spi_read_n), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .spi_readyfordata(spi_readyfordata), .spi_dataavailable(spi_dataavailable),
    .x_pos(x_pos), .y_pos(y_pos), .sample_valid(sample_valid), .pen_down(pen_down),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    spi_readyfordata  = 1'b1;
    spi_dataavailable = 1'b0;
  end

  // SPI core register model: txdata starts a byte, rxdata read clears RRDY, control drives SSO.
  always @(negedge clk) begin
    cycle++;
    if (spi_select && !spi_write_n && prev_wr_n && spi_mem_addr == 3'd3) begin
      sso = spi_wdata[10];
      adc_phase = 0;
    end
    if (spi_select && !spi_write_n && prev_wr_n && spi_mem_addr == 3'd1) begin
      mosi_q.push_back(spi_wdata[7:0]);
      cur_tx = spi_wdata[7:0];
      last_tx_cycle = cycle;
      spi_readyfordata  = 1'b0;
      spi_dataavailable = 1'b0;
      busy_cnt = BYTE_TIME;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        case (adc_phase)
          1:       rx_reg = {1'b1, adc_val[11:5]};
          2:       rx_reg = {adc_val[4:0], 3'b101};
          default: rx_reg = 8'h5A;
        endcase
        if (cur_tx[7]) begin
          adc_val = (cur_tx[6:4] == 3'b101) ? x_val : ((cur_tx[6:4] == 3'b001) ? y_val : 12'h000);
          adc_phase = 1;
        end else if (adc_phase == 1) begin
          adc_phase = 2;
        end else begin
          adc_phase = 0;
        end
        spi_readyfordata = 1'b1;
        if (!mute_rrdy) spi_dataavailable = 1'b1;
      end
    end
    if (spi_select && !spi_read_n && prev_rd_n && spi_mem_addr == 3'd0) spi_dataavailable = 1'b0;
    prev_wr_n = spi_write_n;
    prev_rd_n = spi_read_n;
  end

  // Output monitors: strobe pulses, pen state, bus activity and access length.
  always @(negedge clk) begin
    if (sample_valid) begin
      sv_count++;
      sv_time.push_back(cycle);
    end
    if (pen_down) pd_seen = 1'b1;
    if (spi_select) sel_cycles++;
    if (!reset_n) begin
      strobe_run = 0;
    end else begin
      if (spi_select != (!spi_write_n || !spi_read_n)) proto_err++;
      if (!spi_write_n || !spi_read_n) begin
        strobe_run++;
      end else begin
        if (strobe_run != 0 && strobe_run != 2) proto_err++;
        strobe_run = 0;
      end
    end
  end

  task automatic clear_logs();
    mosi_q.delete();
    sv_time.delete();
    sv_count = 0;
    sel_cycles = 0;
    pd_seen = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    pen_irq_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (spi_select !== 1'b0) begin errors++; $display("[TB] FAIL reset_select: got %b want 0", spi_select); end
    checks++; if (spi_write_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_write_n: got %b want 1", spi_write_n); end
    checks++; if (spi_read_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_read_n: got %b want 1", spi_read_n); end
    checks++; if (spi_wdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wdata: got %h want 0000", spi_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_sample_valid: got %b want 0", sample_valid); end
    checks++; if (pen_down !== 1'b0) begin errors++; $display("[TB] FAIL reset_pen_down: got %b want 0", pen_down); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err: got %b want 0", timeout_err); end
    checks++; if (x_pos !== 12'h000 || y_pos !== 12'h000) begin errors++; $display("[TB] FAIL reset_pos: got %h/%h want 000/000", x_pos, y_pos); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_pen_glitch();
    clear_logs();
    enable = 1'b1;
    pen_irq_n = 1'b0;
    repeat (20) @(negedge clk);
    pen_irq_n = 1'b1;
    repeat (150) @(negedge clk);
    checks++; if (pd_seen !== 1'b0) begin errors++; $display("[TB] FAIL glitch_pen_down: got %b want 0", pd_seen); end
    checks++; if (sel_cycles != 0) begin errors++; $display("[TB] FAIL glitch_bus: got %0d select cycles want 0", sel_cycles); end
  endtask

  task automatic test_single_frame();
    int n;
    clear_logs();
    pen_irq_n = 1'b0;
    n = 0;
    while (sv_count < 1 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (sv_count < 1) begin errors++; $display("[TB] FAIL single_wait: got %0d pulses want 1", sv_count); end
    repeat (400) @(negedge clk);
    pen_irq_n = 1'b1;
    repeat (DEB + 10) @(negedge clk);
    checks++; if (sv_count != 1) begin errors++; $display("[TB] FAIL single_count: got %0d want 1", sv_count); end
    checks++; if (x_pos !== 12'hA5C) begin errors++; $display("[TB] FAIL single_x: got %h want a5c", x_pos); end
    checks++; if (y_pos !== 12'h3F1) begin errors++; $display("[TB] FAIL single_y: got %h want 3f1", y_pos); end
    checks++; if (mosi_q.size() != 6) begin errors++; $display("[TB] FAIL single_mosi_len: got %0d want 6", mosi_q.size()); end
    for (int i = 0; i < 6 && i < mosi_q.size(); i++) begin
      checks++; if (mosi_q[i] !== exp_mosi[i]) begin errors++; $display("[TB] FAIL single_mosi[%0d]: got %h want %h", i, mosi_q[i], exp_mosi[i]); end
    end
    checks++; if (sso !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: sso %b busy %b want 0 0", sso, busy); end
    checks++; if (pen_down !== 1'b0) begin errors++; $display("[TB] FAIL single_pen_up: got %b want 0", pen_down); end
  endtask

  task automatic test_held_pen();
    int n;
    clear_logs();
    pen_irq_n = 1'b0;
    n = 0;
    while (sv_count < 3 && n < DEB + 3 * SP + 1000) begin @(negedge clk); n++; end
    checks++; if (sv_count < 3) begin errors++; $display("[TB] FAIL held_wait: got %0d pulses want 3", sv_count); end
    repeat (200) @(negedge clk);
    pen_irq_n = 1'b1;
    repeat (SP) @(negedge clk);
    checks++; if (sv_count != 3) begin errors++; $display("[TB] FAIL held_count: got %0d want 3", sv_count); end
    if (sv_time.size() >= 3) begin
      checks++; if (sv_time[1] - sv_time[0] != SP) begin errors++; $display("[TB] FAIL held_gap1: got %0d want %0d", sv_time[1] - sv_time[0], SP); end
      checks++; if (sv_time[2] - sv_time[1] != SP) begin errors++; $display("[TB] FAIL held_gap2: got %0d want %0d", sv_time[2] - sv_time[1], SP); end
    end
    checks++; if (mosi_q.size() != 18) begin errors++; $display("[TB] FAIL held_mosi_len: got %0d want 18", mosi_q.size()); end
    for (int i = 0; i < 18 && i < mosi_q.size(); i++) begin
      checks++; if (mosi_q[i] !== exp_mosi[i % 6]) begin errors++; $display("[TB] FAIL held_mosi[%0d]: got %h want %h", i, mosi_q[i], exp_mosi[i % 6]); end
    end
  endtask

  task automatic test_timeout();
    int n;
    int delta;
    clear_logs();
    mute_rrdy = 1'b1;
    pen_irq_n = 1'b0;
    n = 0;
    while (timeout_err !== 1'b1 && n < DEB + SP + TMO + 1000) begin @(negedge clk); n++; end
    delta = cycle - last_tx_cycle;
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_set: got %b want 1", timeout_err); end
    checks++; if (delta < TMO || delta > TMO + 8) begin errors++; $display("[TB] FAIL timeout_delay: got %0d cycles want %0d..%0d", delta, TMO, TMO + 8); end
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0 || sso !== 1'b0) begin errors++; $display("[TB] FAIL timeout_idle: busy %b sso %b want 0 0", busy, sso); end
    checks++; if (sv_count != 0) begin errors++; $display("[TB] FAIL timeout_no_publish: got %0d want 0", sv_count); end
    checks++; if (mosi_q.size() != 1) begin errors++; $display("[TB] FAIL timeout_mosi_len: got %0d want 1", mosi_q.size()); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b want 1", timeout_err); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear: got %b want 0", timeout_err); end
    pen_irq_n = 1'b1;
    mute_rrdy = 1'b0;
    repeat (DEB + 10) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic test_pen_lift();
    int n;
    clear_logs();
    x_val = 12'h123;
    pen_irq_n = 1'b0;
    n = 0;
    while (mosi_q.size() < 5 && n < DEB + SP + 500) begin @(negedge clk); n++; end
    checks++; if (mosi_q.size() < 5) begin errors++; $display("[TB] FAIL lift_wait: got %0d bytes want 5", mosi_q.size()); end
    pen_irq_n = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks++; if (sv_count != 0) begin errors++; $display("[TB] FAIL lift_no_publish: got %0d want 0", sv_count); end
    checks++; if (x_pos !== 12'hA5C || y_pos !== 12'h3F1) begin errors++; $display("[TB] FAIL lift_pos: got %h/%h want a5c/3f1", x_pos, y_pos); end
    checks++; if (mosi_q.size() != 6) begin errors++; $display("[TB] FAIL lift_mosi_len: got %0d want 6", mosi_q.size()); end
    checks++; if (sso !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL lift_idle: sso %b busy %b want 0 0", sso, busy); end
    repeat (DEB + 10) @(negedge clk);
    checks++; if (pen_down !== 1'b0) begin errors++; $display("[TB] FAIL lift_pen_up: got %b want 0", pen_down); end
    x_val = 12'hA5C;
  endtask

  task automatic test_enable_abort();
    int n;
    clear_logs();
    pen_irq_n = 1'b0;
    n = 0;
    while (mosi_q.size() < 2 && n < DEB + SP + 500) begin @(negedge clk); n++; end
    checks++; if (mosi_q.size() < 2) begin errors++; $display("[TB] FAIL abort_wait: got %0d bytes want 2", mosi_q.size()); end
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks++; if (mosi_q.size() != 2) begin errors++; $display("[TB] FAIL abort_mosi_len: got %0d want 2", mosi_q.size()); end
    checks++; if (sv_count != 0) begin errors++; $display("[TB] FAIL abort_no_publish: got %0d want 0", sv_count); end
    checks++; if (sso !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: sso %b busy %b want 0 0", sso, busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL abort_timeout_err: got %b want 0", timeout_err); end
    pen_irq_n = 1'b1;
    repeat (DEB + 10) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    clear_logs();
    pen_irq_n = 1'b0;
    n = 0;
    while (!(spi_write_n === 1'b0 && spi_mem_addr === 3'd1) && n < DEB + SP + 500) begin @(negedge clk); n++; end
    checks++; if (spi_write_n !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_wait: write_n %b want 0", spi_write_n); end
    reset_n = 1'b0;
    #1;
    checks++; if (spi_write_n !== 1'b1 || spi_select !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_bus: write_n %b select %b want 1 0", spi_write_n, spi_select); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
    n = 0;
    while (sv_count < 1 && n < DEB + 1000) begin @(negedge clk); n++; end
    checks++; if (sv_count != 1) begin errors++; $display("[TB] FAIL rst_mid_publish: got %0d want 1", sv_count); end
    checks++; if (x_pos !== 12'hA5C || y_pos !== 12'h3F1) begin errors++; $display("[TB] FAIL rst_mid_pos: got %h/%h want a5c/3f1", x_pos, y_pos); end
    checks++; if (mosi_q.size() != 6) begin errors++; $display("[TB] FAIL rst_mid_mosi_len: got %0d want 6", mosi_q.size()); end
    pen_irq_n = 1'b1;
    repeat (DEB + 10) @(negedge clk);
  endtask

  task automatic test_bus_protocol();
    checks++; if (proto_err != 0) begin errors++; $display("[TB] FAIL bus_protocol: got %0d violations want 0", proto_err); end
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    pen_irq_n = 1'b1;
    test_reset();
    test_pen_glitch();
    test_single_frame();
    test_held_pen();
    test_timeout();
    test_pen_lift();
    test_enable_abort();
    test_reset_mid_frame();
    test_bus_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
